// File: rtl/avmm_pio_pkg.sv
// avmm_pio_pkg: shared definitions for the avmm_pio_gen2 Avalon-MM GPIO port.
//   - reg_addr_e : word addresses of the register map
//   - EDGE_*     : edge-capture selectors used by the EDGE_TYPE parameter
//   - edge_bit() : per-bit edge event for a given edge type
package avmm_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Event for one bit given the current and previous synchronised samples.
  // Unknown edge types fall back to rising.
  function automatic logic edge_bit(input int edge_type, input logic cur, input logic prev);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_type)
      EDGE_FALL: return fall;
      EDGE_ANY:  return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: input synchroniser and edge detector for the GPIO pins.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : raw asynchronous pin inputs (WIDTH)
//   in_sync      : in_port after SYNC_STAGES flops (WIDTH)
//   ev           : per-bit edge event of the kind chosen by EDGE_TYPE (WIDTH)
module pio_sync_edge
  import avmm_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] ev
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev;

  // NOTE: the synchroniser chain is a small array of flops, not a RAM, so it
  // is reset like any other register; a reset pulse must leave no stale
  // sample that could later look like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: a default before the loop keeps this purely combinational.
    ev = '0;
    for (int i = 0; i < WIDTH; i++) ev[i] = edge_bit(EDGE_TYPE, in_sync[i], in_prev[i]);
  end

endmodule

// File: rtl/avmm_pio_gen2.sv
// avmm_pio_gen2: parametrised Avalon-MM slave GPIO port with per-bit
// direction, atomic set/clear, synchronised inputs, edge capture and a
// masked level interrupt. Zero wait states; reads have no side effects.
//   clk, reset_n          : clock, asynchronous active-low reset
//   address[2:0]          : word address (see reg_addr_e)
//   chipselect, write_n   : write strobe is chipselect & ~write_n
//   writedata[31:0]       : write data, bits above WIDTH ignored
//   readdata[31:0]        : combinational read data, bits above WIDTH are 0
//   in_port[WIDTH-1:0]    : asynchronous pin inputs
//   out_port[WIDTH-1:0]   : output data, driven only on output-direction bits
//   oe[WIDTH-1:0]         : output enable, equal to the direction register
//   irq                   : level interrupt, |(edge_cap & irq_mask)
module avmm_pio_gen2
  import avmm_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2,
  parameter int               IRQ_EN      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] rd;
  logic             unused_wd;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  // Upper write-data bits are architecturally ignored when WIDTH < 32.
  assign unused_wd = ^writedata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .in_sync(in_sync),
    .ev     (ev)
  );

  // Write-1-to-clear strobe for the capture register.
  assign clr = (wr && address == ADDR_EDGECAP) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      // A new event outranks a simultaneous clear so no edge is ever lost.
      edge_cap <= ev | (edge_cap & ~clr);
      if (wr) begin
        case (reg_addr_e'(address))
          ADDR_DATA:    data_out <= wd;
          ADDR_DIR:     dir      <= wd;
          ADDR_IRQMASK: irq_mask <= (IRQ_EN != 0) ? wd : '0;
          ADDR_OUTSET:  data_out <= data_out | wd;
          ADDR_OUTCLR:  data_out <= data_out & ~wd;
          default:      ;
        endcase
      end
    end
  end

  // Input-direction bits keep their data_out value but drive nothing until
  // the direction flips to output.
  assign out_port = data_out & dir;
  assign oe       = dir;
  assign irq      = (IRQ_EN != 0) && |(edge_cap & irq_mask);

  always_comb begin
    rd = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:    rd = (data_out & dir) | (in_sync & ~dir);
      ADDR_DIR:     rd = dir;
      ADDR_IRQMASK: rd = irq_mask;
      ADDR_EDGECAP: rd = edge_cap;
      default:      rd = '0;
    endcase
  end

  always_comb begin
    readdata            = '0;
    readdata[WIDTH-1:0] = rd;
  end

endmodule

// File: tb/tb_avmm_pio_gen2.sv
// tb_avmm_pio_gen2: directed stimulus with a scoreboard. Stimulus pushes the
// expected value of each observed output into a queue; a monitor on the
// falling clock edge pops every pending entry and compares it with the DUT.
module tb_avmm_pio_gen2;
  import avmm_pio_pkg::*;

  localparam int         WIDTH = 8;
  localparam logic [7:0] R_OUT = 8'hA5;
  localparam logic [7:0] R_DIR = 8'hFF;

  typedef enum {K_READ, K_OUT, K_OE, K_IRQ} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic [WIDTH-1:0] out_port;
  logic [WIDTH-1:0] oe;
  logic             irq;

  always #5 clk = ~clk;

  avmm_pio_gen2 #(
    .WIDTH      (WIDTH),
    .RESET_OUT  (R_OUT),
    .RESET_DIR  (R_DIR),
    .EDGE_TYPE  (EDGE_RISE),
    .SYNC_STAGES(2),
    .IRQ_EN     (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .oe        (oe),
    .irq       (irq)
  );

  // Monitor
  exp_t        cur;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        K_READ:  act = readdata;
        K_OUT:   act = 32'(out_port);
        K_OE:    act = 32'(oe);
        default: act = 32'(irq);
      endcase
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input kind_e k, input logic [31:0] e, input string n);
    exp_t x;
    x.name = n;
    x.kind = k;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    tick();
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string n);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    expect_val(K_READ, e, n);
    @(negedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  task automatic expect_pins(input logic [31:0] o, input logic [31:0] e, input logic [31:0] i,
                             input string n);
    expect_val(K_OUT, o, {n, ".out_port"});
    expect_val(K_OE,  e, {n, ".oe"});
    expect_val(K_IRQ, i, {n, ".irq"});
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset values
    tick();
    expect_pins(32'hA5, 32'hFF, 0, "reset");
    bus_read(ADDR_EDGECAP, 32'h0, "reset.edgecap");
    bus_read(ADDR_IRQMASK, 32'h0, "reset.irqmask");
    bus_read(3'd6, 32'h0, "reset.addr6");

    // Atomic set/clear, upper write bits ignored
    bus_write(ADDR_DATA, 32'hFFFF_FF0F);
    expect_pins(32'h0F, 32'hFF, 0, "data_wr");
    bus_write(ADDR_OUTCLR, 32'h0000_0003);
    expect_pins(32'h0C, 32'hFF, 0, "outclr");
    bus_write(ADDR_OUTSET, 32'hABCD_0030);
    expect_pins(32'h3C, 32'hFF, 0, "outset");
    bus_read(ADDR_OUTSET, 32'h0, "outset.read");
    bus_read(ADDR_OUTCLR, 32'h0, "outclr.read");
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(ADDR_DATA, 32'h3C, "data.after_reserved_wr");
    bus_read(3'd7, 32'h0, "addr7.read");

    // Mixed direction: upper nibble output, lower nibble input
    bus_write(ADDR_DIR, 32'hF0);
    bus_write(ADDR_DATA, 32'hAA);
    in_port = 8'h05;
    repeat (3) tick();
    bus_read(ADDR_DATA, 32'hA5, "mixed.data");
    expect_pins(32'hA0, 32'hF0, 0, "mixed");
    bus_read(ADDR_DIR, 32'hF0, "mixed.dir");
    bus_read(ADDR_EDGECAP, 32'h05, "mixed.edgecap");
    bus_write(ADDR_EDGECAP, 32'h05);
    bus_read(ADDR_EDGECAP, 32'h00, "mixed.edgecap_clr");
    in_port = 8'h00;
    repeat (4) tick();
    bus_read(ADDR_EDGECAP, 32'h00, "falling_ignored");

    // Rising capture on bit 0 with interrupt, exact latency
    bus_write(ADDR_IRQMASK, 32'h01);
    in_port = 8'h01;
    tick();
    tick();
    expect_val(K_IRQ, 0, "rise.early.irq");
    bus_read(ADDR_EDGECAP, 32'h00, "rise.early.edgecap");
    tick();
    expect_val(K_IRQ, 1, "rise.irq");
    bus_read(ADDR_EDGECAP, 32'h01, "rise.edgecap");
    bus_write(ADDR_EDGECAP, 32'h01);
    expect_val(K_IRQ, 0, "rise.clr.irq");
    bus_read(ADDR_EDGECAP, 32'h00, "rise.clr.edgecap");
    in_port = 8'h00;
    repeat (4) tick();
    expect_val(K_IRQ, 0, "fall.irq");
    bus_read(ADDR_EDGECAP, 32'h00, "fall.edgecap");

    // Event on bit 2 coincides with a write-1-to-clear of bit 2
    tick();
    in_port = 8'h04;
    tick();
    tick();
    address    = ADDR_EDGECAP;
    writedata  = 32'h04;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    bus_read(ADDR_EDGECAP, 32'h04, "collision.edgecap");

    // Mid-operation asynchronous reset
    in_port = 8'hFF;
    repeat (4) tick();
    bus_write(ADDR_IRQMASK, 32'hFF);
    bus_write(ADDR_DIR, 32'h0F);
    bus_write(ADDR_DATA, 32'h12);
    expect_pins(32'h02, 32'h0F, 1, "pre_reset");
    bus_read(ADDR_EDGECAP, 32'hFF, "pre_reset.edgecap");
    bus_read(ADDR_DATA, 32'hF2, "pre_reset.data");
    tick();
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    expect_val(K_OUT, 32'hA5, "async_reset.out_port");
    expect_val(K_OE,  32'hFF, "async_reset.oe");
    expect_val(K_IRQ, 0,      "async_reset.irq");
    bus_read(ADDR_EDGECAP, 32'h00, "async_reset.edgecap");
    bus_read(ADDR_IRQMASK, 32'h00, "async_reset.irqmask");
    bus_read(ADDR_DATA, 32'hA5, "async_reset.data");

    in_port = 8'h00;
    repeat (2) tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
